// File: rtl/key_event_encoder_pkg.sv
// Shared note-code constants and event bundle for the key path.
// The hit detector decodes targets with the same codes.
package key_event_encoder_pkg;

    localparam logic [1:0] KEY_CODE_NONE = 2'b00;
    localparam logic [1:0] KEY_CODE_K1   = 2'b01;
    localparam logic [1:0] KEY_CODE_K2   = 2'b10;
    localparam logic [1:0] KEY_CODE_K0   = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } key_event_t;

    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/key_event_encoder_debouncer.sv
// One key: 2-flop synchronizer, debounce counter, stable level
// and a one-cycle pulse on each accepted press.
module key_debouncer
    import key_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic reset_b,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
                press_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            meta_q   <= key_n_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            level_q  <= ~stable_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/key_event_encoder.sv
// Debounced one-shot note-code events from KEY[2:0] with a one-entry
// holding register, valid/ready handshake and saturating drop count.
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int DROP_W          = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [2:0]        key_n,
    input  logic              enable,
    input  logic              event_ready,
    output logic              event_valid,
    output logic [1:0]        event_code,
    output logic [2:0]        key_level,
    output logic [DROP_W-1:0] drop_count
);

    localparam int SUM_W = DROP_W + 1;

    logic [2:0]        press;
    logic [2:0]        level;
    logic [2:0]        edges;
    logic [1:0]        win_code;
    logic [1:0]        loss;
    logic [SUM_W-1:0]  sum;
    key_event_t        evt_q, evt_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    for (genvar i = 0; i < 3; i++) begin : g_deb
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset_b(reset_b),
            .key_n_i(key_n[i]),
            .level_o(level[i]),
            .press_o(press[i])
        );
    end

    // KEY[1] outranks KEY[2], which outranks KEY[0]
    always_comb begin
        if (edges[1])      win_code = KEY_CODE_K1;
        else if (edges[2]) win_code = KEY_CODE_K2;
        else               win_code = KEY_CODE_K0;
    end

    always_comb begin
        edges = enable ? press : 3'b000;
        evt_d = evt_q;
        loss  = count3(edges) - {1'b0, |edges};
        if (evt_q.valid && event_ready) begin
            evt_d = '{valid: 1'b0, code: KEY_CODE_NONE};
        end
        if (|edges) begin
            if (!evt_q.valid || event_ready) begin
                evt_d = '{valid: 1'b1, code: win_code};
            end else begin
                loss = loss + 2'd1;
            end
        end
        sum    = {1'b0, drop_q} + SUM_W'(loss);
        drop_d = sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            evt_q  <= '{valid: 1'b0, code: KEY_CODE_NONE};
            drop_q <= '0;
        end else begin
            evt_q  <= evt_d;
            drop_q <= drop_d;
        end
    end

    assign event_valid = evt_q.valid;
    assign event_code  = evt_q.code;
    assign key_level   = level;
    assign drop_count  = drop_q;

endmodule
